// File: rtl/mc_lat_responder_if.sv
// MC request/response port: the initiator side uses the master modport and the
// responder uses the slave modport.
interface mc_lat_responder_if #(
   parameter int MC_RTNCTL_WIDTH = 32
);
   logic                       mc_rq_vld;
   logic [2:0]                 mc_rq_cmd;
   logic [3:0]                 mc_rq_scmd;
   logic [47:0]                mc_rq_vadr;
   logic [1:0]                 mc_rq_size;
   logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
   logic [63:0]                mc_rq_data;
   logic                       mc_rq_flush;
   logic                       mc_rq_stall;
   logic                       mc_rs_vld;
   logic [2:0]                 mc_rs_cmd;
   logic [3:0]                 mc_rs_scmd;
   logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
   logic [63:0]                mc_rs_data;
   logic                       mc_rs_stall;

   modport master (
      output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
             mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
      input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data
   );

   modport slave (
      input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
             mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
      output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data
   );
endinterface

// File: rtl/mc_lat_responder.sv
// MC responder: local RAM, fixed-latency in-order responses, credit back-pressure.
// Optional macro MC_STALL_INJECT_EN adds LFSR-driven random request stall.
module mc_lat_responder #(
   parameter int MC_RTNCTL_WIDTH = 32,
   parameter int RAM_DEPTH       = 512,
   parameter int LATENCY         = 8,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   mc_lat_responder_if.slave  mc,
   output logic               ovf_err
);
   localparam int AW = $clog2(RAM_DEPTH);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int OW = PW + 1;
   localparam logic [OW-1:0] OCC_FULL  = OW'(FIFO_DEPTH);
   localparam logic [OW-1:0] OCC_STALL = OW'(FIFO_DEPTH - 2);
   localparam logic [2:0] RQ_RD          = 3'd1;
   localparam logic [2:0] RQ_WR          = 3'd2;
   localparam logic [2:0] RS_RD_DATA     = 3'd2;
   localparam logic [2:0] RS_WR_CMPLT    = 3'd3;
   localparam logic [2:0] RS_FLUSH_CMPLT = 3'd4;

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_HOLD} pop_state_t;

   logic [63:0]                ram [RAM_DEPTH];
   logic [AW-1:0]              rq_idx;
   logic                       rq_is_flush, rq_is_rd, rq_is_wr, rq_take, acc_ok;
   logic [2:0]                 rq_rs_cmd;

   logic                       dl_vld_p  [LATENCY];
   logic [2:0]                 dl_cmd_p  [LATENCY];
   logic [MC_RTNCTL_WIDTH-1:0] dl_tag_p  [LATENCY];
   logic [63:0]                dl_data_p [LATENCY];

   logic [2:0]                 fifo_cmd  [FIFO_DEPTH];
   logic [MC_RTNCTL_WIDTH-1:0] fifo_tag  [FIFO_DEPTH];
   logic [63:0]                fifo_data [FIFO_DEPTH];
   logic [PW:0]                wr_ptr, rd_ptr;
   logic                       fifo_wr, fifo_empty, pop;

   logic [OW-1:0]              occ, occ_nxt;
   logic                       stall_occ_r;
   pop_state_t                 state, state_nxt;

   logic                       rs_vld_r;
   logic [2:0]                 rs_cmd_r;
   logic [MC_RTNCTL_WIDTH-1:0] rs_tag_r;
   logic [63:0]                rs_data_r;
   logic                       unused_ok;

   // Request decode: flush wins over cmd; unknown commands are not accepted
   assign rq_idx      = mc.mc_rq_vadr[3 +: AW];
   assign rq_is_flush = mc.mc_rq_flush;
   assign rq_is_rd    = !rq_is_flush && (mc.mc_rq_cmd == RQ_RD);
   assign rq_is_wr    = !rq_is_flush && (mc.mc_rq_cmd == RQ_WR);
   assign rq_take     = mc.mc_rq_vld && (rq_is_flush || rq_is_rd || rq_is_wr);
   assign acc_ok      = rq_take && (occ != OCC_FULL);
   assign rq_rs_cmd   = rq_is_flush ? RS_FLUSH_CMPLT : (rq_is_wr ? RS_WR_CMPLT : RS_RD_DATA);
   assign unused_ok   = ^{mc.mc_rq_scmd, mc.mc_rq_size, mc.mc_rq_vadr[2:0],
                          mc.mc_rq_vadr[47:3+AW]};

   always_ff @(posedge clk) begin
      if (acc_ok && rq_is_wr) ram[rq_idx] <= mc.mc_rq_data;
   end

   // Delay line stage 0 captures the request; stage LATENCY-1 feeds the FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) dl_vld_p[i] <= 1'b0;
      end else begin
         dl_vld_p[0] <= acc_ok;
         for (int i = 1; i < LATENCY; i++) dl_vld_p[i] <= dl_vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      dl_cmd_p[0]  <= rq_rs_cmd;
      dl_tag_p[0]  <= mc.mc_rq_rtnctl;
      dl_data_p[0] <= rq_is_rd ? ram[rq_idx] : 64'h0;
      for (int i = 1; i < LATENCY; i++) begin
         dl_cmd_p[i]  <= dl_cmd_p[i-1];
         dl_tag_p[i]  <= dl_tag_p[i-1];
         dl_data_p[i] <= dl_data_p[i-1];
      end
   end

   // Response FIFO; occupancy accounting guarantees it never overfills
   assign fifo_wr    = dl_vld_p[LATENCY-1];
   assign fifo_empty = (wr_ptr == rd_ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         fifo_cmd[wr_ptr[PW-1:0]]  <= dl_cmd_p[LATENCY-1];
         fifo_tag[wr_ptr[PW-1:0]]  <= dl_tag_p[LATENCY-1];
         fifo_data[wr_ptr[PW-1:0]] <= dl_data_p[LATENCY-1];
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && !mc.mc_rs_stall) begin
               pop       = 1'b1;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND, ST_HOLD: begin
            if (mc.mc_rs_stall) begin
               state_nxt = ST_HOLD;
            end else if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = ST_SEND;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Occupancy spans the delay line and the FIFO so stall reflects in-flight work
   assign occ_nxt = occ + {{PW{1'b0}}, acc_ok} - {{PW{1'b0}}, pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         occ         <= '0;
         stall_occ_r <= 1'b0;
         ovf_err     <= 1'b0;
      end else begin
         state       <= state_nxt;
         occ         <= occ_nxt;
         stall_occ_r <= (occ_nxt >= OCC_STALL);
         if (rq_take && (occ == OCC_FULL)) ovf_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_vld_r  <= 1'b0;
         rs_cmd_r  <= '0;
         rs_tag_r  <= '0;
         rs_data_r <= '0;
      end else begin
         rs_vld_r <= pop;
         if (pop) begin
            rs_cmd_r  <= fifo_cmd[rd_ptr[PW-1:0]];
            rs_tag_r  <= fifo_tag[rd_ptr[PW-1:0]];
            rs_data_r <= fifo_data[rd_ptr[PW-1:0]];
         end
      end
   end

   assign mc.mc_rs_vld    = rs_vld_r;
   assign mc.mc_rs_cmd    = rs_cmd_r;
   assign mc.mc_rs_scmd   = 4'h0;
   assign mc.mc_rs_rtnctl = rs_tag_r;
   assign mc.mc_rs_data   = rs_data_r;

`ifdef MC_STALL_INJECT_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR, taps 16,14,13,11; stall when the low 3 bits are zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 16'hACE1;
      else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign mc.mc_rq_stall = stall_occ_r | (lfsr[2:0] == 3'b000);
`else
   assign mc.mc_rq_stall = stall_occ_r;
`endif

endmodule

// File: tb/tb_mc_lat_responder.sv
// Bench for mc_lat_responder: directed vector table, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
module tb_mc_lat_responder;
   localparam int W          = 32;
   localparam int RAM_DEPTH  = 512;
   localparam int LATENCY    = 8;
   localparam int FIFO_DEPTH = 16;

   typedef struct {
      logic [2:0]  cmd;
      logic        flush;
      logic [47:0] adr;
      logic [31:0] tag;
      logic [63:0] data;
      logic [2:0]  exp_cmd;
      logic [63:0] exp_data;
   } vec_t;

   typedef struct {
      logic [2:0]  cmd;
      logic [31:0] tag;
      logic [63:0] data;
      int          cyc;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ovf_err;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   rsp_t cap_q[$];
   rsp_t exp_q[$];
   logic [63:0] ram_m [int];

   mc_lat_responder_if #(.MC_RTNCTL_WIDTH(W)) mc ();

   mc_lat_responder #(
      .MC_RTNCTL_WIDTH(W),
      .RAM_DEPTH(RAM_DEPTH),
      .LATENCY(LATENCY),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mc(mc),
      .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && mc.mc_rs_vld) begin
         rsp_t r;
         r.cmd  = mc.mc_rs_cmd;
         r.tag  = mc.mc_rs_rtnctl;
         r.data = mc.mc_rs_data;
         r.cyc  = cyc;
         cap_q.push_back(r);
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] cmd, input logic flush, input logic [47:0] adr,
                        input logic [31:0] tag, input logic [63:0] data, output int acc_cyc);
      mc.mc_rq_vld    = 1'b1;
      mc.mc_rq_cmd    = cmd;
      mc.mc_rq_flush  = flush;
      mc.mc_rq_vadr   = adr;
      mc.mc_rq_rtnctl = tag;
      mc.mc_rq_data   = data;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      mc.mc_rq_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cap(input int n, input int budget, input string name);
      int k = 0;
      while (cap_q.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk(name, 64'(cap_q.size() >= n), 64'd1);
   endtask

   vec_t tbl[6];
   int   acc[6];
   int   a;

   initial begin
      mc.mc_rq_vld = 1'b0; mc.mc_rq_cmd = '0; mc.mc_rq_scmd = '0; mc.mc_rq_vadr = '0;
      mc.mc_rq_size = 2'd3; mc.mc_rq_rtnctl = '0; mc.mc_rq_data = '0; mc.mc_rq_flush = 1'b0;
      mc.mc_rs_stall = 1'b0;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rq_stall", 64'(mc.mc_rq_stall), 64'd0);
      chk("rst_rs_vld", 64'(mc.mc_rs_vld), 64'd0);
      chk("rst_ovf", 64'(ovf_err), 64'd0);
      rst_n = 1'b1;
      idle(2);
      chk("post_rst_rs_vld", 64'(mc.mc_rs_vld), 64'd0);
      chk("post_rst_rs_data", mc.mc_rs_data, 64'd0);

      // vector table: write/read, wrap, read-after-write, flush leaves RAM intact
      tbl[0] = '{3'd2, 1'b0, 48'h40,   32'd5,  64'hDEADBEEF,          3'd3, 64'h0};
      tbl[1] = '{3'd1, 1'b0, 48'h40,   32'd6,  64'h0,                 3'd2, 64'hDEADBEEF};
      tbl[2] = '{3'd2, 1'b0, 48'h1000, 32'd7,  64'h123456789ABCDEF0,  3'd3, 64'h0};
      tbl[3] = '{3'd1, 1'b0, 48'h0,    32'd8,  64'h0,                 3'd2, 64'h123456789ABCDEF0};
      tbl[4] = '{3'd1, 1'b1, 48'h0,    32'hA,  64'hFFFFFFFFFFFFFFFF,  3'd4, 64'h0};
      tbl[5] = '{3'd1, 1'b0, 48'h0,    32'd9,  64'h0,                 3'd2, 64'h123456789ABCDEF0};
      cap_q.delete();
      for (int i = 0; i < 6; i++)
         issue(tbl[i].cmd, tbl[i].flush, tbl[i].adr, tbl[i].tag, tbl[i].data, acc[i]);
      wait_cap(6, 4 * LATENCY, "tbl_count");
      for (int i = 0; i < 6; i++) begin
         if (i < cap_q.size()) begin
            chk($sformatf("tbl%0d_cmd", i), 64'(cap_q[i].cmd), 64'(tbl[i].exp_cmd));
            chk($sformatf("tbl%0d_tag", i), 64'(cap_q[i].tag), 64'(tbl[i].tag));
            chk($sformatf("tbl%0d_data", i), cap_q[i].data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_lat", i), 64'(cap_q[i].cyc - acc[i]), 64'(LATENCY + 1));
         end
      end
      chk("rs_scmd", 64'(mc.mc_rs_scmd), 64'd0);

      // unknown command produces no response
      idle(2);
      cap_q.delete();
      issue(3'd5, 1'b0, 48'h40, 32'd77, 64'h0, a);
      idle(2 * LATENCY);
      chk("badcmd_none", 64'(cap_q.size()), 64'd0);

      // back-pressure: 14 reads held by response stall
      cap_q.delete();
      mc.mc_rs_stall = 1'b1;
      for (int i = 0; i < 14; i++) begin
         issue(3'd1, 1'b0, 48'(i * 8), 32'(100 + i), 64'h0, a);
         if (i >= 12) chk($sformatf("bp_rq_stall%0d", i + 1), 64'(mc.mc_rq_stall), 64'(i == 13));
      end
      idle(2 * LATENCY);
      chk("bp_no_rsp", 64'(cap_q.size()), 64'd0);
      chk("bp_ovf", 64'(ovf_err), 64'd0);
      mc.mc_rs_stall = 1'b0;
      wait_cap(14, 40, "bp_count");
      for (int i = 0; i < 14; i++) begin
         if (i < cap_q.size()) begin
            chk($sformatf("bp_tag%0d", i), 64'(cap_q[i].tag), 64'(100 + i));
            chk($sformatf("bp_cyc%0d", i), 64'(cap_q[i].cyc - cap_q[0].cyc), 64'(i));
         end
      end
      idle(2);
      chk("bp_stall_clear", 64'(mc.mc_rq_stall), 64'd0);

      // overflow: 17 requests against a stalled response port
      cap_q.delete();
      mc.mc_rs_stall = 1'b1;
      for (int i = 0; i < 17; i++) begin
         issue(3'd1, 1'b0, 48'h40, 32'(200 + i), 64'h0, a);
         if (i >= 15) chk($sformatf("ovf_after%0d", i + 1), 64'(ovf_err), 64'(i == 16));
      end
      idle(LATENCY + 2);
      mc.mc_rs_stall = 1'b0;
      wait_cap(16, 60, "ovf_count_min");
      idle(2 * LATENCY);
      chk("ovf_count", 64'(cap_q.size()), 64'd16);
      if (cap_q.size() > 0) chk("ovf_last_tag", 64'(cap_q[cap_q.size()-1].tag), 64'd215);
      chk("ovf_sticky", 64'(ovf_err), 64'd1);

      // reset with responses queued
      cap_q.delete();
      mc.mc_rs_stall = 1'b1;
      for (int i = 0; i < 5; i++) issue(3'd1, 1'b0, 48'h40, 32'(300 + i), 64'h0, a);
      idle(3);
      rst_n = 1'b0;
      #2;
      chk("mrst_rq_stall", 64'(mc.mc_rq_stall), 64'd0);
      chk("mrst_rs_vld", 64'(mc.mc_rs_vld), 64'd0);
      chk("mrst_rs_cmd", 64'(mc.mc_rs_cmd), 64'd0);
      chk("mrst_rs_tag", 64'(mc.mc_rs_rtnctl), 64'd0);
      chk("mrst_rs_data", mc.mc_rs_data, 64'd0);
      chk("mrst_ovf", 64'(ovf_err), 64'd0);
      idle(2);
      rst_n = 1'b1;
      mc.mc_rs_stall = 1'b0;
      idle(2 * LATENCY);
      chk("mrst_no_rsp", 64'(cap_q.size()), 64'd0);

      // randomized traffic against the reference model
      begin
         int acc_n = 0;
         int popped;
         cap_q.delete();
         exp_q.delete();
         ram_m.delete();
         for (int c = 0; c < 800; c++) begin
            popped = cap_q.size() + (mc.mc_rs_vld ? 1 : 0);
            chk("rnd_rq_stall", 64'(mc.mc_rq_stall), 64'((acc_n - popped) >= FIFO_DEPTH - 2));
            mc.mc_rs_stall = ($urandom_range(0, 3) == 0);
            mc.mc_rq_vld = 1'b0;
            if (!mc.mc_rq_stall && $urandom_range(0, 2) != 0) begin
               int   kind = $urandom_range(0, 9);
               int   idx  = $urandom_range(0, 15);
               rsp_t e;
               mc.mc_rq_vld    = 1'b1;
               mc.mc_rq_flush  = 1'b0;
               mc.mc_rq_vadr   = {16'($urandom), 20'($urandom), 9'(idx), 3'($urandom)};
               mc.mc_rq_rtnctl = $urandom;
               mc.mc_rq_data   = {$urandom, $urandom};
               mc.mc_rq_scmd   = 4'($urandom);
               mc.mc_rq_size   = 2'($urandom);
               e.tag = mc.mc_rq_rtnctl;
               e.cyc = 0;
               if (kind >= 6 && !ram_m.exists(idx)) kind = 2;
               if (kind == 0) begin
                  mc.mc_rq_cmd = (($urandom_range(0, 1) == 0) ? 3'd0 : 3'(3 + $urandom_range(0, 4)));
               end else begin
                  if (kind == 1) begin
                     mc.mc_rq_flush = 1'b1;
                     mc.mc_rq_cmd   = 3'($urandom);
                     e.cmd = 3'd4; e.data = 64'h0;
                  end else if (kind <= 5) begin
                     mc.mc_rq_cmd = 3'd2;
                     ram_m[idx] = mc.mc_rq_data;
                     e.cmd = 3'd3; e.data = 64'h0;
                  end else begin
                     mc.mc_rq_cmd = 3'd1;
                     e.cmd = 3'd2; e.data = ram_m[idx];
                  end
                  exp_q.push_back(e);
                  acc_n++;
               end
            end
            @(posedge clk);
            #1;
         end
         mc.mc_rq_vld = 1'b0;
         mc.mc_rs_stall = 1'b0;
         wait_cap(exp_q.size(), 200, "rnd_drain");
         idle(4);
         chk("rnd_count", 64'(cap_q.size()), 64'(exp_q.size()));
         for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            chk($sformatf("rnd%0d_cmd", i), 64'(cap_q[i].cmd), 64'(exp_q[i].cmd));
            chk($sformatf("rnd%0d_tag", i), 64'(cap_q[i].tag), 64'(exp_q[i].tag));
            chk($sformatf("rnd%0d_data", i), cap_q[i].data, exp_q[i].data);
         end
         chk("rnd_ovf", 64'(ovf_err), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
